icache_refill_unit: RTL

//  Line-refill engine directly upstream of the L1 instruction cache. On an icache miss it

---
 rtl/icache_refill_unit_if.sv | 43 ++++
 rtl/icache_refill_unit.sv | 110 +++++++++++
 2 files changed

// File: rtl/icache_refill_unit_if.sv
// icache_refill_unit_if
//   System-bus read channel between the icache refill engine and the bus.
//   The refill engine is the master: it raises a request, then takes the response beats.
//   Signals:
//     bus_reqcyc   master -> slave  request valid
//     bus_req      master -> slave  line-aligned request address
//     bus_reqtag   master -> slave  request tag
//     bus_reqack   slave  -> master request accepted
//     bus_respcyc  slave  -> master response beat valid
//     bus_resp     slave  -> master response beat data
//     bus_respack  master -> slave  response beat accepted
interface icache_refill_unit_if #(
  parameter int TAG_WIDTH  = 13,
  parameter int DATA_WIDTH = 64
);
  logic                  bus_reqcyc;
  logic [63:0]           bus_req;
  logic [TAG_WIDTH-1:0]  bus_reqtag;
  logic                  bus_reqack;
  logic                  bus_respcyc;
  logic [DATA_WIDTH-1:0] bus_resp;
  logic                  bus_respack;

  modport master (
    output bus_reqcyc,
    output bus_req,
    output bus_reqtag,
    input  bus_reqack,
    input  bus_respcyc,
    input  bus_resp,
    output bus_respack
  );

  modport slave (
    input  bus_reqcyc,
    input  bus_req,
    input  bus_reqtag,
    output bus_reqack,
    output bus_respcyc,
    output bus_resp,
    input  bus_respack
  );
endinterface

// File: rtl/icache_refill_unit.sv
// icache_refill_unit
//   Line-refill engine sitting in front of the L1 instruction cache. On a miss it issues one
//   64-byte line read, gathers the eight 64-bit response beats into a 512-bit line and reports
//   fill progress in bits. The icache writes the line once out_offset reads 512.
//   Ports:
//     clk, reset   clock (rising edge) and synchronous active-high reset
//     in_miss      icache miss request
//     in_pc        fetch PC of the missing instruction
//     in_stall     icache cannot take the finished line yet
//     bus          system-bus read channel (master side)
//     out_data     assembled 512-bit line
//     out_offset   fill progress in bits, 0..512 in steps of 64
module icache_refill_unit #(
  parameter int                       BUS_TAG_WIDTH  = 13,
  parameter int                       BUS_DATA_WIDTH = 64,
  parameter logic [BUS_TAG_WIDTH-1:0] READ_TAG       = 13'h1100
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_miss,
  input  logic [63:0]                   in_pc,
  input  logic                          in_stall,
  icache_refill_unit_if.master          bus,
  output logic [8*BUS_DATA_WIDTH-1:0]   out_data,
  output logic [9:0]                    out_offset
);

  localparam logic [9:0] BEAT_BITS = 10'(BUS_DATA_WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP,
    DONE
  } state_t;

  state_t     state;
  logic [3:0] beat_cnt;

  // The low PC bits only select a byte inside the line; they never reach the bus.
  logic unused_pc_bits;
  assign unused_pc_bits = ^in_pc[5:0];

  // Beats are accepted while filling, and also in IDLE so that late beats of a read
  // aborted by reset are drained instead of stalling the bus. REQ and DONE never ack.
  always_comb begin
    bus.bus_respack = 1'b0;
    case (state)
      IDLE:    bus.bus_respack = bus.bus_respcyc;
      RESP:    bus.bus_respack = bus.bus_respcyc;
      default: bus.bus_respack = 1'b0;
    endcase
  end

  // Refill sequencer: IDLE latches the miss address, REQ holds the request until the bus
  // takes it, RESP stores beats in arrival order, DONE presents the finished line until the
  // icache is able to write it. Misses are only picked up in IDLE, so they serialise.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      bus.bus_reqcyc  <= 1'b0;
      bus.bus_req     <= '0;
      bus.bus_reqtag  <= '0;
      out_offset      <= '0;
      out_data        <= '0;
      beat_cnt        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_miss) begin
            bus.bus_req    <= {in_pc[63:6], 6'b0};
            bus.bus_reqtag <= READ_TAG;
            bus.bus_reqcyc <= 1'b1;
            beat_cnt       <= '0;
            state          <= REQ;
          end
        end
        REQ: begin
          if (bus.bus_reqack) begin
            bus.bus_reqcyc <= 1'b0;
            bus.bus_reqtag <= '0;
            state          <= RESP;
          end
        end
        RESP: begin
          // The counter stops at 8 and the state leaves RESP on the eighth beat, so the
          // offset can never step past a full line.
          if (bus.bus_respcyc && (beat_cnt < 4'd8)) begin
            out_data[int'(beat_cnt[2:0])*BUS_DATA_WIDTH +: BUS_DATA_WIDTH] <= bus.bus_resp;
            out_offset <= out_offset + BEAT_BITS;
            beat_cnt   <= beat_cnt + 4'd1;
            if (beat_cnt == 4'd7) begin
              state <= DONE;
            end
          end
        end
        DONE: begin
          // The line stays on out_data after the handoff; only the offset returns to 0.
          if (!in_stall) begin
            out_offset <= '0;
            beat_cnt   <= '0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
